mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage access controller between the EX/MEM pipeline register and the data cache. It turns the load/store controls held in EX/MEM into a single word-aligned cache request with byte strobes, and stalls the pipeline until the cache acknowledges or the access times out. It returns the raw 32-bit read word on mem_datamem, which feeds the MEM/WB register. Sub-word extraction by Load_sel happens in WB.

## Interface
- TIMEOUT_CYCLES, 1023: maximum cycles in BUSY before the access is aborted (bus error).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset rst, synchronous, active-high.
- ex_MemRd  in  1  load in the MEM stage (from EX/MEM).
- ex_MemWr  in  1  store in the MEM stage.
- ex_Store_sel  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- mem_addr  in  32  effective address (ALU result).
- mem_wdata  in  32  store data; low byte/half holds the value.
- dc_req  out  1  cache request, registered.
- dc_we  out  1  1 = write, 0 = read.
- dc_addr  out  32  {mem_addr[31:2], 2'b00}.
- dc_wdata  out  32  lane-replicated store data.
- dc_be  out  4  byte strobes.
- dc_ack  in  1  cache completion; valid only while dc_req = 1.
- dc_rdata  in  32  read word, valid with dc_ack.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- mem_datamem  out  32  last completed load word.
- misalign_err  out  1  one-cycle pulse, misaligned access.
- bus_err  out  1  one-cycle pulse, timeout abort.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Access condition: (ex_MemRd | ex_MemWr) and the address is aligned.
  - On access: mem_stall = 1 combinationally, next state BUSY. Request fields are registered at this edge.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - On misaligned: no request, no stall, misalign_err pulses the next cycle, mem_datamem unchanged.
- BUSY:
  - dc_req = 1; mem_stall = 1.
  - dc_addr, dc_we, dc_wdata and dc_be are held stable until dc_ack.
  - The timeout counter increments each cycle.
  - On dc_ack: dc_req drops at the next edge. If the access was a read, mem_datamem <= dc_rdata. Next state DONE.
  - On counter == TIMEOUT_CYCLES-1 without dc_ack: bus_err pulse, mem_datamem <= 0 for reads, next state DONE.
- DONE:
  - mem_stall = 0 for exactly one cycle so the pipeline advances. Next state IDLE.
  - This guarantees the same instruction is never issued twice.
- ex_MemRd and ex_MemWr both set: executed as a store.
- Store lanes:
  - Byte: dc_be = 4'b0001 << addr[1:0]; dc_wdata = byte replicated ×4.
  - Half: dc_be = addr[1] ? 1100 : 0011; dc_wdata = half replicated ×2.
  - Word: dc_be = 1111; dc_wdata = mem_wdata.
- Loads: dc_we = 0, dc_be = 1111.
- Stores never modify mem_datamem.
- dc_ack outside BUSY is ignored.
- Counter clears on entry to BUSY.

## Timing
- Reset values: state IDLE, dc_req 0, dc_we 0, dc_addr 0, dc_wdata 0, dc_be 0, mem_datamem 0, misalign_err 0, bus_err 0, counter 0. mem_stall = 0 while rst is high.
- Access detected in cycle N:
  - dc_req is high from N+1.
  - With ack in cycle N+k (k ≥ 1), DONE is cycle N+k+1 and mem_datamem is valid from N+k+1.
  - mem_stall is high in cycles N..N+k. Minimum total stall is 2 cycles.
- mem_datamem stays valid through the negedge capture into MEM/WB in the DONE cycle.
- Timeout: dc_req is high for exactly TIMEOUT_CYCLES cycles. bus_err is high in the DONE cycle.
- Reset mid-transaction: dc_req drops at the next edge with no further handshake. The cache must tolerate an abandoned request.
- Back-to-back accesses: the next access is detected in the cycle after DONE. There is no idle gap beyond DONE.

## Test plan
- Word load, addr 0x100, ack one cycle after req with rdata 0xDEADBEEF:
  - dc_addr 0x100, dc_be 1111, dc_we 0.
  - mem_stall high for 2 cycles.
  - mem_datamem = 0xDEADBEEF in the DONE cycle.
- Byte store, addr 0x203, wdata 0x000000A5:
  - dc_addr 0x200, dc_be 1000, dc_wdata 0xA5A5A5A5.
  - mem_datamem unchanged.
- Half store to 0x102, then a half load to 0x101:
  - Store: dc_be 1100.
  - Load: misalign_err pulses, no dc_req, no stall.
- Load with no ack, TIMEOUT_CYCLES = 8:
  - dc_req high for exactly 8 cycles.
  - bus_err pulses; mem_datamem = 0.
  - FSM returns to IDLE.
- rst asserted in the 2nd BUSY cycle of a load:
  - Next cycle: dc_req 0, mem_stall 0, all outputs at reset values.
  - A later ack is ignored.
- Back-to-back load then store, each acked after 3 cycles:
  - Two distinct requests; each instruction advances once.
  - mem_stall pattern: 1,1,1,1,0,1,1,1,1,0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: turns EX/MEM load/store controls into one
// word-aligned data-cache request and stalls the pipeline until ack or timeout.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_MemRd,
    input  logic        ex_MemWr,
    input  logic [1:0]  ex_Store_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        dc_req,
    output logic        dc_we,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_be,
    input  logic        dc_ack,
    input  logic [31:0] dc_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_datamem,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state_q;
    logic          req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   data_q;
    logic          misalign_q;
    logic          bus_err_q;
    logic [CW-1:0] cnt_q;

    logic          is_half;
    logic          is_word;
    logic          misalign;
    logic          access;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;

    always_comb begin
        is_half  = (ex_Store_sel == 2'b01);
        is_word  = ex_Store_sel[1];
        misalign = (is_half & mem_addr[0]) |
                   (is_word & (mem_addr[1:0] != 2'b00));
        access   = (ex_MemRd | ex_MemWr) & ~misalign;

        be_d    = 4'hF;
        wdata_d = mem_wdata;
        case (ex_Store_sel)
            2'b00: begin
                be_d    = 4'b0001 << mem_addr[1:0];
                wdata_d = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{mem_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'hF;
                wdata_d = mem_wdata;
            end
        endcase
        // A load (or anything without MemWr) always reads the full word
        if (!ex_MemWr) be_d = 4'hF;

        mem_stall = ~rst & ((state_q == BUSY) |
                            ((state_q == IDLE) & access));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            data_q     <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        state_q <= BUSY;
                        req_q   <= 1'b1;
                        we_q    <= ex_MemWr;
                        addr_q  <= {mem_addr[31:2], 2'b00};
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        cnt_q   <= '0;
                    end else if (ex_MemRd | ex_MemWr) begin
                        misalign_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dc_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        if (!we_q) data_q <= dc_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                        if (!we_q) data_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // One unstalled cycle lets EX/MEM take the next instruction
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dc_req       = req_q;
    assign dc_we        = we_q;
    assign dc_addr      = addr_q;
    assign dc_wdata     = wdata_q;
    assign dc_be        = be_q;
    assign mem_datamem  = data_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule
